video_pix_feeder: RTL and testbench

//  Pixel source for the HDMI timing generator. Buffers the incoming pixel stream
//  (valid/ready, start-of-frame flag) in a first-word-fall-through FIFO.

---
 rtl/video_pix_feeder.sv | 151 +++++++++++++++
 tb/tb_video_pix_feeder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/video_pix_feeder.sv
// Pixel source for the HDMI timing generator: a FWFT FIFO of {sof, pixel} entries
// plus a small FSM that locks each requested frame to the stream's start-of-frame flag.
module video_pix_feeder #(
    parameter int              DATA_W     = 24,
    parameter int              FIFO_AW    = 10,
    parameter int              X_BITS     = 12,
    parameter int              Y_BITS     = 12,
    parameter logic [DATA_W-1:0] FILL_COLOR = '0
) (
    input  logic                 pix_clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_sof,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 pix_req,
    input  logic [X_BITS-1:0]    pix_x,
    input  logic [Y_BITS-1:0]    pix_y,
    output logic [DATA_W-1:0]    pix_data,
    output logic [FIFO_AW:0]     fifo_level,
    output logic                 locked,
    output logic                 underflow,
    output logic                 sync_err,
    output logic [15:0]          underflow_cnt
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2
    } state_t;

    logic [DATA_W:0]     mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_reg;
    logic [FIFO_AW-1:0]  rd_ptr_reg;
    logic [FIFO_AW:0]    level_reg;
    state_t              state_reg;
    state_t              state_next;
    logic [DATA_W-1:0]   pix_data_reg;
    logic                locked_reg;
    logic                underflow_reg;
    logic                sync_err_reg;
    logic [15:0]         underflow_cnt_reg;

    logic                empty;
    logic                push;
    logic                pop;
    logic                head_sof;
    logic [DATA_W-1:0]   head_data;
    logic                fs;
    logic [DATA_W-1:0]   out_next;
    logic                underflow_next;
    logic                sync_err_next;

    assign empty     = (level_reg == '0);
    assign s_ready   = (level_reg != (FIFO_AW+1)'(DEPTH));
    assign push      = s_valid & s_ready;
    assign head_sof  = mem[rd_ptr_reg][DATA_W];
    assign head_data = mem[rd_ptr_reg][DATA_W-1:0];
    assign fs        = pix_req & (pix_x == X_BITS'(1)) & (pix_y == Y_BITS'(1));

    // Head decode: decides the pop, the next pixel value and the error pulses.
    always_comb begin
        pop            = 1'b0;
        out_next       = FILL_COLOR;
        underflow_next = 1'b0;
        sync_err_next  = 1'b0;
        state_next     = state_reg;
        case (state_reg)
            FLUSH: begin
                if (!empty) begin
                    if (!head_sof) pop = 1'b1;
                    else           state_next = ARMED;
                end
            end
            ARMED: begin
                if (fs && !empty) begin
                    pop        = 1'b1;
                    out_next   = head_data;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (pix_req) begin
                    if (empty) begin
                        underflow_next = 1'b1;
                    end else if (fs) begin
                        if (head_sof) begin
                            pop      = 1'b1;
                            out_next = head_data;
                        end else begin
                            sync_err_next = 1'b1;
                            state_next    = FLUSH;
                        end
                    end else if (head_sof) begin
                        // Next frame arrived before this one finished.
                        sync_err_next = 1'b1;
                        state_next    = ARMED;
                    end else begin
                        pop      = 1'b1;
                        out_next = head_data;
                    end
                end
            end
            default: state_next = FLUSH;
        endcase
    end

    always_ff @(posedge pix_clk) begin
        if (push) mem[wr_ptr_reg] <= {s_sof, s_data};
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            level_reg         <= '0;
            state_reg         <= FLUSH;
            pix_data_reg      <= '0;
            locked_reg        <= 1'b0;
            underflow_reg     <= 1'b0;
            sync_err_reg      <= 1'b0;
            underflow_cnt_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            state_reg     <= state_next;
            locked_reg    <= (state_next == STREAM);
            underflow_reg <= underflow_next;
            sync_err_reg  <= sync_err_next;
            if (pix_req) pix_data_reg <= out_next;
            if (underflow_next && underflow_cnt_reg != 16'hFFFF)
                underflow_cnt_reg <= underflow_cnt_reg + 1'b1;
        end
    end

    assign pix_data      = pix_data_reg;
    assign fifo_level    = level_reg;
    assign locked        = locked_reg;
    assign underflow     = underflow_reg;
    assign sync_err      = sync_err_reg;
    assign underflow_cnt = underflow_cnt_reg;

endmodule

// File: tb/tb_video_pix_feeder.sv
// Directed bench for video_pix_feeder on a 4x2 frame with an 8-entry FIFO;
// expected request results go through a scoreboard queue.
module tb_video_pix_feeder;

    localparam int          DW   = 24;
    localparam int          AW   = 3;
    localparam int          XB   = 12;
    localparam int          YB   = 12;
    localparam logic [23:0] FILL = 24'hF0F0F0;

    logic          pix_clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_sof = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          pix_req = 1'b0;
    logic [XB-1:0] pix_x = '0;
    logic [YB-1:0] pix_y = '0;
    logic [DW-1:0] pix_data;
    logic [AW:0]   fifo_level;
    logic          locked;
    logic          underflow;
    logic          sync_err;
    logic [15:0]   underflow_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] data;
        logic        uf;
        logic        se;
    } exp_t;
    exp_t sb[$];

    video_pix_feeder #(
        .DATA_W    (DW),
        .FIFO_AW   (AW),
        .X_BITS    (XB),
        .Y_BITS    (YB),
        .FILL_COLOR(FILL)
    ) dut (
        .pix_clk      (pix_clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_sof        (s_sof),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .pix_req      (pix_req),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_data     (pix_data),
        .fifo_level   (fifo_level),
        .locked       (locked),
        .underflow    (underflow),
        .sync_err     (sync_err),
        .underflow_cnt(underflow_cnt)
    );

    always #5 pix_clk = ~pix_clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_data  = 24'h00DEAD;
        pix_req = 1'b0;
        tick();
        tick();
        rst     = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        sb.delete();
    endtask

    task automatic push(input logic [23:0] data, input logic sof);
        int n = 0;
        s_data  = data;
        s_sof   = sof;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("push_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic req(input string tag, input int x, input int y,
                       input logic [23:0] exp_data, input logic exp_uf, input logic exp_se);
        exp_t e;
        pix_req = 1'b1;
        pix_x   = XB'(x);
        pix_y   = YB'(y);
        sb.push_back('{exp_data, exp_uf, exp_se});
        tick();
        pix_req = 1'b0;
        e = sb.pop_front();
        check({tag, "_data"}, 32'(pix_data), 32'(e.data));
        check({tag, "_uf"}, 32'(underflow), 32'(e.uf));
        check({tag, "_se"}, 32'(sync_err), 32'(e.se));
        $display("req %s x=%0d y=%0d pix_data=%06h uf=%0b se=%0b", tag, x, y, pix_data, underflow, sync_err);
    endtask

    initial begin
        // 1: reset with s_valid held high
        do_reset();
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_ucnt", 32'(underflow_cnt), 32'd0);

        // 2: normal frame
        for (int k = 0; k < 8; k++) push(24'(k + 1), k == 0);
        tick();
        check("t2_level_full", 32'(fifo_level), 32'd8);
        check("t2_armed_unlocked", 32'(locked), 32'd0);
        for (int k = 0; k < 8; k++) begin
            req("t2", k % 4 + 1, k / 4 + 1, 24'(k + 1), 1'b0, 1'b0);
            check("t2_locked", 32'(locked), 32'd1);
        end
        check("t2_level_empty", 32'(fifo_level), 32'd0);

        // 3: leading garbage gets flushed
        do_reset();
        for (int k = 0; k < 3; k++) push(24'hBAD001 + 24'(k), 1'b0);
        for (int k = 0; k < 8; k++) push(24'h000011 + 24'(k), k == 0);
        tick();
        tick();
        check("t3_level", 32'(fifo_level), 32'd8);
        for (int k = 0; k < 8; k++)
            req("t3", k % 4 + 1, k / 4 + 1, 24'h000011 + 24'(k), 1'b0, 1'b0);

        // 4: underflow on the last two requests
        do_reset();
        for (int k = 0; k < 6; k++) push(24'h000021 + 24'(k), k == 0);
        tick();
        for (int k = 0; k < 8; k++)
            req("t4", k % 4 + 1, k / 4 + 1, (k < 6) ? 24'h000021 + 24'(k) : FILL, k >= 6, 1'b0);
        check("t4_ucnt", 32'(underflow_cnt), 32'd2);
        check("t4_locked", 32'(locked), 32'd1);

        // 5: short frame followed by a new SOF
        do_reset();
        for (int k = 0; k < 5; k++) push(24'h000031 + 24'(k), k == 0);
        for (int k = 0; k < 3; k++) push(24'h000041 + 24'(k), k == 0);
        tick();
        for (int k = 0; k < 5; k++)
            req("t5a", k % 4 + 1, k / 4 + 1, 24'h000031 + 24'(k), 1'b0, 1'b0);
        req("t5_early", 2, 2, FILL, 1'b0, 1'b1);
        check("t5_unlocked", 32'(locked), 32'd0);
        req("t5_armed3", 3, 2, FILL, 1'b0, 1'b0);
        req("t5_armed4", 4, 2, FILL, 1'b0, 1'b0);
        for (int k = 3; k < 8; k++) push(24'h000041 + 24'(k), 1'b0);
        for (int k = 0; k < 8; k++)
            req("t5b", k % 4 + 1, k / 4 + 1, 24'h000041 + 24'(k), 1'b0, 1'b0);
        check("t5_locked", 32'(locked), 32'd1);

        // 6: backpressure at full FIFO
        do_reset();
        for (int k = 0; k < 8; k++) push(24'h000051 + 24'(k), k == 0);
        s_data  = 24'h000059;
        s_sof   = 1'b0;
        s_valid = 1'b1;
        tick();
        tick();
        tick();
        check("t6_ready_full", 32'(s_ready), 32'd0);
        check("t6_level_full", 32'(fifo_level), 32'd8);
        req("t6_first", 1, 1, 24'h000051, 1'b0, 1'b0);
        check("t6_ready_after_pop", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("t6_level_refill", 32'(fifo_level), 32'd8);
        for (int k = 1; k < 8; k++)
            req("t6", k % 4 + 1, k / 4 + 1, 24'h000051 + 24'(k), 1'b0, 1'b0);
        req("t6_ninth", 1, 3, 24'h000059, 1'b0, 1'b0);
        check("t6_level_empty", 32'(fifo_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
